// File: rtl/buffer_ctrl_pkg.sv
// Shared definitions for the LPC capture buffer sequencer: default geometry,
// frame field layout and drop counter width.
package buffer_ctrl_pkg;

   localparam int DEFAULT_AW   = 4;
   localparam int DEFAULT_DW   = 48;
   localparam int DROP_COUNT_W = 16;

   // Frame layout: LPC address in the low 32 bits, data byte, then cycle type/dir
   localparam int ADDR_LSB = 0;
   localparam int ADDR_MSB = 31;
   localparam int DATA_LSB = 32;
   localparam int DATA_MSB = 39;
   localparam int TYPE_LSB = 40;
   localparam int TYPE_MSB = 47;

   typedef struct packed {
      logic [TYPE_MSB-TYPE_LSB:0] cyc_type;
      logic [DATA_MSB-DATA_LSB:0] data;
      logic [ADDR_MSB-ADDR_LSB:0] addr;
   } lpc_frame_t;

   // Saturating increment used by the drop counter
   function automatic logic [DROP_COUNT_W-1:0] sat_inc(input logic [DROP_COUNT_W-1:0] v);
      return (v == {DROP_COUNT_W{1'b1}}) ? v : v + DROP_COUNT_W'(1);
   endfunction

endpackage

// File: rtl/buffer_ptr.sv
// FIFO pointer register: W bits wide (one extra wrap bit over the RAM address),
// increments on inc, synchronous clear, asynchronous active-low reset.
module buffer_ptr #(
   parameter int W = 5
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] ptr
);

   logic [W-1:0] ptr_reg;

   // Pointer state: clear wins over increment; wrap at 2**W is natural
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         ptr_reg <= '0;
      else if (clear)
         ptr_reg <= '0;
      else if (inc)
         ptr_reg <= ptr_reg + W'(1);
   end

   assign ptr = ptr_reg;

endmodule

// File: rtl/buffer_ctrl.sv
// FIFO sequencer for the LPC sniffer capture buffer. Frames from the decoder are
// written into an external RAM (no backpressure; frames arriving while full are
// dropped), then moved into a registered valid/ready output for the UART serializer.
// Build option: define BUFFER_CTRL_DROP_COUNT_EN to add a saturating 16-bit
// drop_count output alongside the sticky overflow flag.
module buffer_ctrl
   import buffer_ctrl_pkg::*;
#(
   parameter int AW = DEFAULT_AW,
   parameter int DW = DEFAULT_DW
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          clear,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          mem_write_en,
   output logic [AW-1:0] mem_write_addr,
   output logic [DW-1:0] mem_write_data,
   output logic [AW-1:0] mem_read_addr,
   input  logic [DW-1:0] mem_read_data,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   level,
   output logic          overflow
`ifdef BUFFER_CTRL_DROP_COUNT_EN
   ,
   output logic [DROP_COUNT_W-1:0] drop_count
`endif
);

   logic [AW:0]   wptr;
   logic [AW:0]   rptr;
   logic          load;
   logic          drop;
   logic          out_valid_reg;
   logic [DW-1:0] out_data_reg;
   logic          overflow_reg;

   buffer_ptr #(.W(AW + 1)) u_wptr (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (clear),
      .inc     (mem_write_en),
      .ptr     (wptr)
   );

   buffer_ptr #(.W(AW + 1)) u_rptr (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (clear),
      .inc     (load),
      .ptr     (rptr)
   );

   // Occupancy flags and handshake decisions, all from pre-edge state
   always_comb begin
      empty = (wptr == rptr);
      full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
      level = wptr - rptr;
      // reset_n gating keeps the RAM strobe quiet while reset is held
      mem_write_en = in_valid & ~full & ~clear & reset_n;
      drop         = in_valid & full & ~clear;
      load         = ~empty & (~out_valid_reg | out_ready) & ~clear;
   end

   assign mem_write_addr = wptr[AW-1:0];
   assign mem_write_data = in_data;
   assign mem_read_addr  = rptr[AW-1:0];

   // Output register: refill from RAM when free or being consumed; data held while stalled
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
      end else if (clear) begin
         out_valid_reg <= 1'b0;
      end else if (load) begin
         out_valid_reg <= 1'b1;
         out_data_reg  <= mem_read_data;
      end else if (out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

   // Sticky overflow flag: set by any dropped frame until reset or clear
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         overflow_reg <= 1'b0;
      else if (clear)
         overflow_reg <= 1'b0;
      else if (drop)
         overflow_reg <= 1'b1;
   end

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign overflow  = overflow_reg;

`ifdef BUFFER_CTRL_DROP_COUNT_EN
   logic [DROP_COUNT_W-1:0] drop_count_reg;

   // Saturating count of dropped frames
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         drop_count_reg <= '0;
      else if (clear)
         drop_count_reg <= '0;
      else if (drop)
         drop_count_reg <= sat_inc(drop_count_reg);
   end

   assign drop_count = drop_count_reg;
`endif

endmodule
